alu_result_stage: RTL

ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

---
 rtl/alu_result_stage_if.sv | 28 ++
 rtl/alu_result_stage.sv | 89 ++++++++
 2 files changed

// File: rtl/alu_result_stage_if.sv
// Handshake/bus bundle between the adder, the result stage and writeback.
// The DUT side uses slave; the producer/consumer side uses master.
interface alu_result_stage_if #(
  parameter int WIDTH = 16
);
  logic             IN_VALID;
  logic             IN_READY;
  logic             CTRL;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] S;
  logic             COUT;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [WIDTH-1:0] RESULT;
  logic [3:0]       FLAGS;
  logic [7:0]       OVF_CNT;

  modport slave (
    input  IN_VALID, CTRL, A, B, S, COUT, OUT_READY,
    output IN_READY, OUT_VALID, RESULT, FLAGS, OVF_CNT
  );

  modport master (
    output IN_VALID, CTRL, A, B, S, COUT, OUT_READY,
    input  IN_READY, OUT_VALID, RESULT, FLAGS, OVF_CNT
  );
endinterface

// File: rtl/alu_result_stage.sv
// Two-entry in-order buffer capturing adder sum and {Z,N,C,V} flags,
// with a saturating count of signed-overflow results.
module alu_result_stage #(
  parameter int WIDTH = 16
) (
  input logic               CLK,
  input logic               RST,
  alu_result_stage_if.slave bus
);
  localparam int MSB = WIDTH - 1;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic [3:0]       flg;
  } entry_t;

  entry_t     mem_q [2];
  entry_t     mem_d [2];
  logic       rd_q, rd_d;
  logic       wr_q, wr_d;
  logic [1:0] cnt_q, cnt_d;
  logic       rdy_q, rdy_d;
  logic [7:0] ovf_q, ovf_d;

  logic   push, pop;
  logic   z, n, c, v;
  entry_t new_e;

  assign push = bus.IN_VALID & rdy_q;
  assign pop  = (cnt_q != 2'd0) & bus.OUT_READY;

  always_comb begin
    z = (bus.S == '0);
    n = bus.S[MSB];
    c = bus.COUT;
    // Subtract flips B's sign, so the same-sign test becomes differing signs.
    if (bus.CTRL)
      v = (bus.A[MSB] != bus.B[MSB]) & (bus.S[MSB] != bus.A[MSB]);
    else
      v = (bus.A[MSB] == bus.B[MSB]) & (bus.S[MSB] != bus.A[MSB]);
    new_e = '{res: bus.S, flg: {z, n, c, v}};
  end

  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (push) begin
      mem_d[wr_q] = new_e;
      wr_d        = ~wr_q;
      if (v && ovf_q != 8'hFF)
        ovf_d = ovf_q + 8'd1;
    end
    if (pop)
      rd_d = ~rd_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
    rdy_d = (cnt_d != 2'd2);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      mem_q <= '{default: '0};
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      cnt_q <= 2'd0;
      rdy_q <= 1'b1;
      ovf_q <= 8'd0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      rdy_q <= rdy_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.IN_READY  = rdy_q;
  assign bus.OUT_VALID = (cnt_q != 2'd0);
  assign bus.RESULT    = mem_q[rd_q].res;
  assign bus.FLAGS     = mem_q[rd_q].flg;
  assign bus.OVF_CNT   = ovf_q;
endmodule
